// File: rtl/bcd_display_counter_pkg.sv
// Shared BCD digit and seven-segment types plus the digit decoder.
// Segments are active-low, bit order g..a.
package bcd_display_counter_pkg;

  typedef logic [3:0] bcd_t;
  typedef logic [6:0] seg_t;

  localparam seg_t SEG_BLANK = 7'b1111111;

  function automatic seg_t bcd_to_seg(input bcd_t d);
    case (d)
      4'd0:    bcd_to_seg = 7'b1000000;
      4'd1:    bcd_to_seg = 7'b1111001;
      4'd2:    bcd_to_seg = 7'b0100100;
      4'd3:    bcd_to_seg = 7'b0110000;
      4'd4:    bcd_to_seg = 7'b0011001;
      4'd5:    bcd_to_seg = 7'b0010010;
      4'd6:    bcd_to_seg = 7'b0000010;
      4'd7:    bcd_to_seg = 7'b1111000;
      4'd8:    bcd_to_seg = 7'b0000000;
      4'd9:    bcd_to_seg = 7'b0010000;
      default: bcd_to_seg = SEG_BLANK;
    endcase
  endfunction

endpackage

// File: rtl/bcd_display_counter_digit.sv
// One BCD decade: load with sanitising, increment/decrement when the
// carry/borrow chain reaches it, and a carry/borrow out to the next decade.
module bcd_digit
  import bcd_display_counter_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic up,
  input  bcd_t load_d,
  input  logic cin,
  output bcd_t q,
  output logic cout,
  output logic bad
);

  logic at_limit;

  assign bad      = (load_d > 4'd9);
  assign at_limit = up ? (q == 4'd9) : (q == 4'd0);
  assign cout     = cin & at_limit;

  // cin is already gated by load at the chain head, so load wins here too.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      q <= 4'd0;
    else if (load)
      q <= bad ? 4'd0 : load_d;
    else if (cin) begin
      if (up) q <= at_limit ? 4'd0 : q + 4'd1;
      else    q <= at_limit ? 4'd9 : q - 4'd1;
    end
  end

endmodule

// File: rtl/bcd_display_counter.sv
// Multi-decade BCD up/down counter with seven-segment decode and optional
// leading-zero blanking. Decades are chained by carry/borrow.
module bcd_display_counter
  import bcd_display_counter_pkg::*;
#(
  parameter int NUM_DIGITS = 2,
  parameter int BLANK_LZ   = 0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    en,
  input  logic                    up,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] load_val,
  output logic [4*NUM_DIGITS-1:0] count,
  output logic [7*NUM_DIGITS-1:0] leds,
  output logic                    wrap,
  output logic                    load_err
);

  logic [NUM_DIGITS-1:0] bad;
  logic                  last_cout;

  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
    logic cin, cout, blank;

    // Per-stage carry nets keep the chain free of a self-referencing vector.
    if (i == 0) begin : g_head
      assign cin = en & ~load;
    end else begin : g_link
      assign cin = g_digit[i-1].cout;
    end

    if (i == NUM_DIGITS-1) begin : g_tail
      assign last_cout = cout;
    end

    bcd_digit u_digit (
      .clk    (clk),
      .reset  (reset),
      .load   (load),
      .up     (up),
      .load_d (load_val[4*i +: 4]),
      .cin    (cin),
      .q      (count[4*i +: 4]),
      .cout   (cout),
      .bad    (bad[i])
    );

    assign blank = (BLANK_LZ != 0) && (i != 0) &&
                   (count[4*NUM_DIGITS-1:4*i] == '0);
    assign leds[7*i +: 7] = blank ? SEG_BLANK : bcd_to_seg(count[4*i +: 4]);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wrap     <= 1'b0;
      load_err <= 1'b0;
    end else begin
      wrap     <= last_cout;
      load_err <= load & (|bad);
    end
  end

endmodule

// File: tb/tb_bcd_display_counter.sv
// Randomised and directed checks of the BCD display counter against an
// integer-valued reference model; a second instance covers blanking.
module tb_bcd_display_counter;

  localparam int ND  = 2;
  localparam int MOD = 100;

  logic          clk = 1'b0;
  logic          reset, en, up, load;
  logic [4*ND-1:0] load_val;
  logic [4*ND-1:0] count, count_b;
  logic [7*ND-1:0] leds, leds_b;
  logic          wrap, wrap_b, load_err, load_err_b;

  int n_chk  = 0;
  int n_fail = 0;

  int m_val  = 0;
  bit m_wrap = 0;
  bit m_err  = 0;

  logic [6:0] seg_tab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                               7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                               7'b0000000, 7'b0010000};

  bcd_display_counter #(.NUM_DIGITS(ND), .BLANK_LZ(0)) dut (
    .clk(clk), .reset(reset), .en(en), .up(up), .load(load),
    .load_val(load_val), .count(count), .leds(leds),
    .wrap(wrap), .load_err(load_err));

  bcd_display_counter #(.NUM_DIGITS(ND), .BLANK_LZ(1)) dut_b (
    .clk(clk), .reset(reset), .en(en), .up(up), .load(load),
    .load_val(load_val), .count(count_b), .leds(leds_b),
    .wrap(wrap_b), .load_err(load_err_b));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [4*ND-1:0] to_bcd(input int v);
    logic [4*ND-1:0] r = '0;
    for (int i = 0; i < ND; i++) begin
      r[4*i +: 4] = 4'((v / (10 ** i)) % 10);
    end
    return r;
  endfunction

  function automatic logic [7*ND-1:0] to_leds(input int v, input bit blz);
    logic [7*ND-1:0] r = '0;
    for (int i = 0; i < ND; i++) begin
      if (blz && i > 0 && (v / (10 ** i)) == 0) r[7*i +: 7] = 7'h7F;
      else                                       r[7*i +: 7] = seg_tab[(v / (10 ** i)) % 10];
    end
    return r;
  endfunction

  task automatic check_all();
    chk("count",      count,      to_bcd(m_val));
    chk("count_b",    count_b,    to_bcd(m_val));
    chk("leds",       leds,       to_leds(m_val, 0));
    chk("leds_blank", leds_b,     to_leds(m_val, 1));
    chk("wrap",       wrap,       m_wrap);
    chk("wrap_b",     wrap_b,     m_wrap);
    chk("load_err",   load_err,   m_err);
    chk("load_err_b", load_err_b, m_err);
  endtask

  // Advance the model from the inputs in force at the coming edge, then check.
  task automatic tick();
    int nv  = m_val;
    bit nw  = 0;
    bit ne  = 0;
    if (reset) begin
      nv = 0;
    end else if (load) begin
      nv = 0;
      for (int i = 0; i < ND; i++) begin
        int d = int'(load_val[4*i +: 4]);
        if (d > 9) begin ne = 1; d = 0; end
        nv += d * (10 ** i);
      end
    end else if (en) begin
      if (up) begin nw = (m_val == MOD-1); nv = (m_val + 1) % MOD; end
      else    begin nw = (m_val == 0);     nv = (m_val + MOD - 1) % MOD; end
    end
    @(posedge clk);
    #1;
    m_val = nv; m_wrap = nw; m_err = ne;
    check_all();
  endtask

  task automatic do_load(input logic [4*ND-1:0] v);
    load = 1; load_val = v; tick(); load = 0;
  endtask

  initial begin
    reset = 1; en = 1; up = 1; load = 0; load_val = '0;
    #1;
    check_all();
    // Reset dominates en and load.
    tick();
    load = 1; load_val = 8'h55; tick(); load = 0;
    reset = 0;

    repeat (12) tick();
    chk("count_is_12", count, 8'h12);

    en = 0; do_load(8'h98);
    en = 1; up = 1; tick(); tick();
    chk("wrap_99_to_00", wrap, 1'b1);
    en = 0; tick();

    do_load(8'h10);
    en = 1; up = 0; repeat (11) tick();
    chk("count_99_after_down", count, 8'h99);
    en = 0; tick();

    en = 1; up = 1; do_load(8'h3C);
    chk("load_err_3c", load_err, 1'b1);
    en = 0; tick();

    do_load(8'h05);
    chk("blank_05", leds_b, {7'h7F, 7'b0010010});
    do_load(8'h00);
    chk("blank_00", leds_b, {7'h7F, 7'b1000000});

    // Asynchronous reset between edges.
    do_load(8'h47);
    #2 reset = 1;
    #1;
    m_val = 0; m_wrap = 0; m_err = 0;
    check_all();
    chk("async_rst_count", count, 8'h00);
    tick();
    reset = 0;
    en = 1; up = 1; tick();

    for (int n = 0; n < 400; n++) begin
      en       = ($urandom_range(0, 3) != 0);
      up       = $urandom_range(0, 1);
      load     = ($urandom_range(0, 9) == 0);
      load_val = 8'($urandom);
      if ($urandom_range(0, 3) == 0) load_val = to_bcd(MOD - 1 - $urandom_range(0, 1) * (MOD - 1));
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
